coin_acceptor: RTL

Upstream front end for the vending FSM. Takes three raw mechanical coin-sensor lines (1-, 2- and 5-unit slots) and synchronises and debounces them. Each clean insertion becomes a one-cycle `money` code (3'd1, 3'd2 or 3'd5) that the vending FSM consumes directly. A small FIFO buffers coins that arrive faster than the output spacing allows. Invalid or unacceptable insertions raise a coin-return pulse.

---
 rtl/coin_acceptor.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/coin_acceptor.sv
// coin_acceptor: synchronise and debounce three coin sensors, buffer accepted coins and emit spaced money codes
module coin_acceptor #(
    parameter int DEB_CYCLES = 16,
    parameter int GAP_CYCLES = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       coin1_in,
    input  logic       coin2_in,
    input  logic       coin5_in,
    input  logic       accept_en,
    output logic [2:0] money,
    output logic       money_valid,
    output logic       coin_return,
    output logic       fifo_full,
    output logic [7:0] reject_cnt
);
    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int NW = AW + 1;

    typedef enum logic [1:0] {IDLE, QUALIFY, HELD, RELEASE} state_t;

    state_t        state_q, state_d;
    logic [2:0]    sync1_q, sync2_q;
    logic [2:0]    lat_q, lat_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [NW-1:0] count_q, count_d;
    logic [7:0]    rej_q, rej_d;
    logic [2:0]    money_q, money_d;
    logic [2:0]    code;
    logic [2:0]    mem_q [FIFO_DEPTH];
    logic          eval, push, pop, reject;
    logic          full_q, ret_q, valid_q;

    // two-flop synchroniser on the raw sensor vector {5, 2, 1}
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= {coin5_in, coin2_in, coin1_in};
            sync2_q <= sync1_q;
        end
    end

    // debounce FSM: qualify a stable press, evaluate it once, then qualify the release
    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        cnt_d   = cnt_q;
        eval    = 1'b0;
        case (state_q)
            IDLE: begin
                if (sync2_q != 3'd0) begin
                    lat_d   = sync2_q;
                    cnt_d   = '0;
                    state_d = QUALIFY;
                end
            end
            QUALIFY: begin
                if (sync2_q != lat_q) state_d = IDLE;
                else if (cnt_q == CW'(DEB_CYCLES)) begin
                    eval    = 1'b1;
                    state_d = HELD;
                end else cnt_d = cnt_q + CW'(1);
            end
            HELD: begin
                if (sync2_q == 3'd0) begin
                    cnt_d   = '0;
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                if (sync2_q != 3'd0) cnt_d = '0;
                else if (cnt_q == CW'(DEB_CYCLES - 1)) state_d = IDLE;
                else cnt_d = cnt_q + CW'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    // accept/reject decision, FIFO bookkeeping and gap-spaced issue
    always_comb begin
        code    = lat_q[0] ? 3'd1 : (lat_q[1] ? 3'd2 : 3'd5);
        push    = eval && $onehot(lat_q) && accept_en && !full_q;
        reject  = eval && !push;
        pop     = (count_q != '0) && (gap_q == '0);
        wr_d    = push ? wr_q + AW'(1) : wr_q;
        rd_d    = pop ? rd_q + AW'(1) : rd_q;
        count_d = (push && !pop) ? count_q + NW'(1) : ((pop && !push) ? count_q - NW'(1) : count_q);
        gap_d   = pop ? GW'(GAP_CYCLES) : ((gap_q != '0) ? gap_q - GW'(1) : gap_q);
        money_d = pop ? mem_q[rd_q] : 3'd0;
        rej_d   = (reject && rej_q != 8'hFF) ? rej_q + 8'd1 : rej_q;
    end

    // state, pointers, counters and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            lat_q   <= '0;
            cnt_q   <= '0;
            gap_q   <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            rej_q   <= '0;
            money_q <= '0;
            valid_q <= 1'b0;
            ret_q   <= 1'b0;
            full_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
            rej_q   <= rej_d;
            money_q <= money_d;
            valid_q <= pop;
            ret_q   <= reject;
            full_q  <= (count_d == NW'(FIFO_DEPTH));
        end
    end

    // coin-code storage; entries are only meaningful while counted as occupied
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= code;
    end

    assign money       = money_q;
    assign money_valid = valid_q;
    assign coin_return = ret_q;
    assign fifo_full   = full_q;
    assign reject_cnt  = rej_q;
endmodule
